// File: rtl/fp_div_issuer.sv
// Start/done issuer for the iterative fp_div + fp_rnd pair: one request in flight, tagged response out.
// Optional build macro FP_DIV_ISSUER_TIMEOUT_EN adds a WAIT watchdog that answers with a canonical qNaN.

package fp_div_issuer_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned fp_exp_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

endpackage

module fp_div_issuer
  import fp_div_issuer_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT      = FP32,
  parameter int unsigned FP_WIDTH       = fp_width(FP_FORMAT),
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [FP_WIDTH-1:0]  req_a_i,
  input  logic [FP_WIDTH-1:0]  req_b_i,
  input  roundmode_e           req_rnd_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  output logic                 div_start_o,
  output logic [FP_WIDTH-1:0]  div_a_o,
  output logic [FP_WIDTH-1:0]  div_b_o,
  output roundmode_e           div_rnd_o,
  input  logic                 div_done_i,
  input  logic [FP_WIDTH-1:0]  div_result_i,
  input  status_t              div_flags_i,
  input  logic                 div_dz_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [FP_WIDTH-1:0]  rsp_result_o,
  output status_t              rsp_flags_o,
  output logic [TAG_WIDTH-1:0] rsp_tag_o,
  output logic                 rsp_timeout_o
);

  localparam int unsigned EXP_W = fp_exp_bits(FP_FORMAT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("fp_div_issuer: TIMEOUT_CYCLES must be at least 2");
  end

  // Sign 0, exponent all ones, mantissa MSB only.
  function automatic logic [FP_WIDTH-1:0] canonical_qnan();
    logic [FP_WIDTH-1:0] ones;
    ones = '1;
    return (ones >> 1) ^ (ones >> (EXP_W + 2));
  endfunction

  function automatic status_t merge_dz(input status_t flags, input logic dz);
    status_t merged;
    merged    = flags;
    merged.DZ = flags.DZ | dz;
    return merged;
  endfunction

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic                 ready_q;
  logic                 start_q;
  logic                 valid_q;
  logic [FP_WIDTH-1:0]  a_q;
  logic [FP_WIDTH-1:0]  b_q;
  roundmode_e           rnd_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [FP_WIDTH-1:0]  result_q;
  status_t              flags_q;
  logic                 timeout_q;
  logic                 timeout_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid_i && ready_q) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (div_done_i || timeout_hit) state_d = S_RESP;
      S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control: state plus registered handshake/strobe outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      start_q <= (state_d == S_LAUNCH);
      valid_q <= (state_d == S_RESP);
    end
  end

  // Operands: captured on accept and held until the next accepted request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q   <= '0;
      b_q   <= '0;
      rnd_q <= RNE;
      tag_q <= '0;
    end else if (state_q == S_IDLE && req_valid_i && ready_q) begin
      a_q   <= req_a_i;
      b_q   <= req_b_i;
      rnd_q <= req_rnd_i;
      tag_q <= req_tag_i;
    end
  end

  // Response: only WAIT looks at done, so stray or late pulses elsewhere are dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state_q == S_WAIT) begin
      if (div_done_i) begin
        result_q <= div_result_i;
        flags_q  <= merge_dz(div_flags_i, div_dz_i);
      end else if (timeout_hit) begin
        result_q <= canonical_qnan();
        flags_q  <= '{NV: 1'b1, default: 1'b0};
      end
    end
  end

`ifdef FP_DIV_ISSUER_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign timeout_hit = (cnt_q == CNT_LAST);

  // Cleared in LAUNCH and frozen at CNT_LAST, so it cannot wrap.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      cnt_q <= '0;
    end else if (state_q == S_WAIT && !div_done_i && !timeout_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timeout_q <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (div_done_i) begin
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
`endif

  assign req_ready_o   = ready_q;
  assign div_start_o   = start_q;
  assign div_a_o       = a_q;
  assign div_b_o       = b_q;
  assign div_rnd_o     = rnd_q;
  assign rsp_valid_o   = valid_q;
  assign rsp_result_o  = result_q;
  assign rsp_flags_o   = flags_q;
  assign rsp_tag_o     = tag_q;
  assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_fp_div_issuer.sv
// Bench for fp_div_issuer: behavioural divider with programmable latency, directed plan cases and
// randomized transactions scored against expectations derived from the request/response rules.
module tb_fp_div_issuer;
  import fp_div_issuer_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_a_i = '0;
  logic [31:0] req_b_i = '0;
  roundmode_e  req_rnd_i = RNE;
  logic [3:0]  req_tag_i = '0;
  logic        div_start_o;
  logic [31:0] div_a_o;
  logic [31:0] div_b_o;
  roundmode_e  div_rnd_o;
  logic        div_done_i = 1'b0;
  logic [31:0] div_result_i = '0;
  status_t     div_flags_i = '0;
  logic        div_dz_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_result_o;
  status_t     rsp_flags_o;
  logic [3:0]  rsp_tag_o;
  logic        rsp_timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  // Divider model controls, written by the main sequence only.
  int          mdl_lat = 10;
  logic        mdl_never = 1'b0;
  logic [31:0] mdl_res = '0;
  logic [4:0]  mdl_flg = '0;
  logic        mdl_dz = 1'b0;
  int          late_req = 0;
  int          late_ack = 0;
  int          mdl_cnt = 0;

  fp_div_issuer #(
    .FP_FORMAT     (FP32),
    .TAG_WIDTH     (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_rnd_i    (req_rnd_i),
    .req_tag_i    (req_tag_i),
    .div_start_o  (div_start_o),
    .div_a_o      (div_a_o),
    .div_b_o      (div_b_o),
    .div_rnd_o    (div_rnd_o),
    .div_done_i   (div_done_i),
    .div_result_i (div_result_i),
    .div_flags_i  (div_flags_i),
    .div_dz_i     (div_dz_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_flags_o  (rsp_flags_o),
    .rsp_tag_o    (rsp_tag_o),
    .rsp_timeout_o(rsp_timeout_o)
  );

  always #5 clk = ~clk;

  // Behavioural divider: done arrives mdl_lat falling edges after start; junk on the data lines otherwise.
  always @(negedge clk) begin
    div_done_i   = 1'b0;
    div_result_i = $urandom;
    div_flags_i  = 5'($urandom);
    div_dz_i     = 1'($urandom);
    if (reset_i) begin
      mdl_cnt = 0;
    end else if (late_req != late_ack) begin
      late_ack   = late_req;
      div_done_i = 1'b1;
    end else if (div_start_o) begin
      mdl_cnt = mdl_lat;
    end else if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0 && !mdl_never) begin
        div_done_i   = 1'b1;
        div_result_i = mdl_res;
        div_flags_i  = mdl_flg;
        div_dz_i     = mdl_dz;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input roundmode_e rnd,
                        input logic [3:0] tag, input int lat, input logic never,
                        input logic [31:0] res, input logic [4:0] flg, input logic dz,
                        input int hold);
    logic [31:0] exp_res;
    logic [4:0]  exp_flg;
    logic        exp_to;
    int          starts;
    int          done_idx;
    int          valid_idx;
    mdl_lat   = lat;
    mdl_never = never;
    mdl_res   = res;
    mdl_flg   = flg;
    mdl_dz    = dz;
    if (never) begin
      exp_res = 32'h7FC0_0000;
      exp_flg = 5'b10000;
      exp_to  = 1'b1;
    end else begin
      exp_res    = res;
      exp_flg    = flg;
      exp_flg[3] = flg[3] | dz;
      exp_to     = 1'b0;
    end

    chk("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_a_i     = a;
    req_b_i     = b;
    req_rnd_i   = rnd;
    req_tag_i   = tag;
    tick();
    req_valid_i = 1'b0;
    req_a_i     = $urandom;
    req_b_i     = $urandom;
    req_tag_i   = 4'($urandom);
    chk("start_n1", div_start_o, 1);
    chk("req_ready_busy", req_ready_o, 0);
    chk("div_a", div_a_o, a);
    chk("div_b", div_b_o, b);
    chk("div_rnd", div_rnd_o, rnd);

    starts    = 0;
    done_idx  = 0;
    valid_idx = 0;
    for (int i = 2; i <= 120 && valid_idx == 0; i++) begin
      tick();
      if (div_start_o) starts++;
      if (div_done_i && done_idx == 0) done_idx = i;
      if (rsp_valid_o) valid_idx = i;
    end
    chk("extra_start", starts, 0);
    if (valid_idx == 0) begin
      chk("rsp_valid_budget", 0, 1);
    end else begin
      chk("rsp_latency", valid_idx, never ? TO + 2 : done_idx);
      chk("rsp_result", rsp_result_o, exp_res);
      chk("rsp_flags", rsp_flags_o, exp_flg);
      chk("rsp_tag", rsp_tag_o, tag);
      chk("rsp_timeout", rsp_timeout_o, exp_to);
      chk("div_a_hold", div_a_o, a);
    end

    for (int h = 0; h < hold; h++) begin
      req_valid_i = 1'b1;
      req_a_i     = $urandom;
      tick();
      chk("bp_valid", rsp_valid_o, 1);
      chk("bp_ready", req_ready_o, 0);
      chk("bp_start", div_start_o, 0);
      chk("bp_result", rsp_result_o, exp_res);
      chk("bp_flags", rsp_flags_o, exp_flg);
      chk("bp_tag", rsp_tag_o, tag);
      chk("bp_div_a", div_a_o, a);
    end

    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("rsp_drop", rsp_valid_o, 0);
    chk("idle_after_rsp", req_ready_o, 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_ready", req_ready_o, 1);
    chk("rst_start", div_start_o, 0);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_timeout", rsp_timeout_o, 0);
    chk("rst_div_a", div_a_o, 0);
    chk("rst_div_b", div_b_o, 0);
    chk("rst_rnd", div_rnd_o, RNE);
    chk("rst_result", rsp_result_o, 0);
    chk("rst_flags", rsp_flags_o, 0);
    chk("rst_tag", rsp_tag_o, 0);
    reset_i = 1'b0;
    tick();

    // Basic divide, divide by zero, long backpressure.
    do_txn(32'h3F80_0000, 32'h4000_0000, RNE, 4'd3, 10, 1'b0, 32'h3F00_0000, 5'b00000, 1'b0, 0);
    do_txn(32'h3F80_0000, 32'h0000_0000, RTZ, 4'd5, 10, 1'b0, 32'h7F80_0000, 5'b00000, 1'b1, 1);
    do_txn(32'h4120_0000, 32'h4080_0000, RUP, 4'd12, 10, 1'b0, 32'h4020_0000, 5'b00001, 1'b0, 20);

`ifdef FP_DIV_ISSUER_TIMEOUT_EN
    do_txn(32'h4000_0000, 32'h4040_0000, RDN, 4'd7, 10, 1'b1, 32'h0, 5'b0, 1'b0, 2);
    late_req++;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_done_valid", rsp_valid_o, 0);
      chk("late_done_ready", req_ready_o, 1);
      chk("late_done_start", div_start_o, 0);
      chk("late_done_result", rsp_result_o, 32'h7FC0_0000);
    end
    do_txn(32'h4080_0000, 32'h4000_0000, RNE, 4'd9, TO, 1'b0, 32'h4000_0000, 5'b00010, 1'b0, 0);
`endif

    // Reset while the divider is busy: the pending response must vanish.
    mdl_lat   = 10;
    mdl_never = 1'b0;
    mdl_res   = 32'hDEAD_BEEF;
    req_valid_i = 1'b1;
    req_a_i     = 32'h4100_0000;
    req_b_i     = 32'h4000_0000;
    req_rnd_i   = RUP;
    req_tag_i   = 4'd6;
    tick();
    req_valid_i = 1'b0;
    repeat (5) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("midrst_valid", rsp_valid_o, 0);
    chk("midrst_ready", req_ready_o, 1);
    chk("midrst_start", div_start_o, 0);
    chk("midrst_div_a", div_a_o, 0);
    chk("midrst_rnd", div_rnd_o, RNE);
    chk("midrst_tag", rsp_tag_o, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("midrst_quiet", rsp_valid_o, 0);
    end
    do_txn(32'h4040_0000, 32'h3F80_0000, RNE, 4'd9, 10, 1'b0, 32'h4040_0000, 5'b00000, 1'b0, 1);

    for (int k = 0; k < 24; k++) begin
      do_txn($urandom, $urandom, roundmode_e'(3'($urandom_range(0, 4))), 4'($urandom),
             $urandom_range(1, TO - 1), 1'b0, $urandom, 5'($urandom), 1'($urandom),
             $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
